// File: rtl/lm80c_ps2_matrix.sv
// PS/2 set-2 scancode to LM80C 8x8 key matrix (active-low rows), with E0/F0/E1 prefix handling.
// Optional Ctrl+Alt+Del reset pulse enabled by defining LM80C_KBD_RESET_COMBO_EN.
module lm80c_ps2_matrix #(
    parameter int E1_SKIP     = 7,
    parameter int RESET_PULSE = 16
) (
    input  logic            sys_clock,
    input  logic            RESET,
    input  logic            ps2_valid,
    input  logic [7:0]      ps2_byte,
    output logic [7:0][7:0] KM,
    output logic            kbd_reset
);
    localparam int SKIP_W = $clog2(E1_SKIP + 1);

    if (E1_SKIP < 1 || RESET_PULSE < 1) begin : g_bad_param
        $error("lm80c_ps2_matrix: E1_SKIP and RESET_PULSE must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_SKIP
    } state_t;

    state_t            state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [7:0][7:0]   km_q, km_d;
    logic              ext_ctx;
    logic              map_hit;
    logic [2:0]        map_row, map_col;
    logic              do_make, do_brk, overrun;

    assign ext_ctx = (state_q == ST_EXT) || (state_q == ST_EXTBRK);

    // Key code {ext, byte[6:0]} -> matrix position; bytes with bit 7 set never map.
    always_comb begin
        map_hit = 1'b0;
        map_row = 3'd0;
        map_col = 3'd0;
        if (!ps2_byte[7]) begin
            case ({ext_ctx, ps2_byte[6:0]})
                8'h1C: begin map_hit = 1'b1; map_row = 3'd2; map_col = 3'd1; end
                8'h1A: begin map_hit = 1'b1; map_row = 3'd5; map_col = 3'd2; end
                8'h29: begin map_hit = 1'b1; map_row = 3'd7; map_col = 3'd4; end
                8'h5A: begin map_hit = 1'b1; map_row = 3'd0; map_col = 3'd1; end
                8'h12: begin map_hit = 1'b1; map_row = 3'd6; map_col = 3'd0; end
                8'h14: begin map_hit = 1'b1; map_row = 3'd6; map_col = 3'd1; end
                8'h11: begin map_hit = 1'b1; map_row = 3'd6; map_col = 3'd2; end
                8'hF5: begin map_hit = 1'b1; map_row = 3'd0; map_col = 3'd6; end
                8'hF1: begin map_hit = 1'b1; map_row = 3'd0; map_col = 3'd7; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        km_d    = km_q;
        do_make = 1'b0;
        do_brk  = 1'b0;
        overrun = 1'b0;
        if (ps2_valid) begin
            if (state_q != ST_SKIP && (ps2_byte == 8'h00 || ps2_byte == 8'hFF)) begin
                overrun = 1'b1;
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        case (ps2_byte)
                            8'hE0: state_d = ST_EXT;
                            8'hF0: state_d = ST_BRK;
                            8'hE1: begin
                                state_d = ST_SKIP;
                                skip_d  = SKIP_W'(E1_SKIP);
                            end
                            8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                            default: do_make = 1'b1;
                        endcase
                    end
                    ST_EXT: begin
                        case (ps2_byte)
                            8'hF0: state_d = ST_EXTBRK;
                            8'hE0: state_d = ST_EXT;
                            8'h12, 8'h59: state_d = ST_IDLE;
                            default: begin
                                do_make = 1'b1;
                                state_d = ST_IDLE;
                            end
                        endcase
                    end
                    ST_BRK: begin
                        do_brk  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    ST_EXTBRK: begin
                        do_brk  = !(ps2_byte == 8'h12 || ps2_byte == 8'h59);
                        state_d = ST_IDLE;
                    end
                    ST_SKIP: begin
                        skip_d = skip_q - 1'b1;
                        if (skip_q <= SKIP_W'(1)) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
        if (overrun) km_d = '1;
        else if (do_make && map_hit) km_d[map_row][map_col] = 1'b0;
        else if (do_brk && map_hit) km_d[map_row][map_col] = 1'b1;
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            km_q    <= '1;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            km_q    <= km_d;
        end
    end

    assign KM = km_q;

`ifdef LM80C_KBD_RESET_COMBO_EN
    localparam int PULSE_W = $clog2(RESET_PULSE + 1);

    logic               ctrl_q, ctrl_d, alt_q, alt_d, del_q, del_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;

    // Held-flags ignore the E0 prefix so left/right and keypad variants all count.
    always_comb begin
        ctrl_d  = ctrl_q;
        alt_d   = alt_q;
        del_d   = del_q;
        pulse_d = pulse_q;
        if (overrun) begin
            ctrl_d = 1'b0;
            alt_d  = 1'b0;
            del_d  = 1'b0;
        end else if ((do_make || do_brk) && !ps2_byte[7]) begin
            case (ps2_byte[6:0])
                7'h14: ctrl_d = do_make;
                7'h11: alt_d  = do_make;
                7'h71: del_d  = do_make;
                default: ;
            endcase
        end
        if (pulse_q != '0) pulse_d = pulse_q - 1'b1;
        if ((ctrl_d && alt_d && del_d) && !(ctrl_q && alt_q && del_q))
            pulse_d = PULSE_W'(RESET_PULSE);
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            ctrl_q  <= 1'b0;
            alt_q   <= 1'b0;
            del_q   <= 1'b0;
            pulse_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            alt_q   <= alt_d;
            del_q   <= del_d;
            pulse_q <= pulse_d;
        end
    end

    assign kbd_reset = (pulse_q != '0);
`else
    assign kbd_reset = 1'b0;
`endif

endmodule

// File: tb/tb_lm80c_ps2_matrix.sv
// Scoreboard bench for lm80c_ps2_matrix: a sequence-level reference model predicts the matrix
// and reset pulse per strobe; a monitor compares them every cycle.
module tb_lm80c_ps2_matrix;
    localparam int E1_SKIP     = 7;
    localparam int RESET_PULSE = 16;
    localparam int NK          = 9;

    logic            sys_clock = 1'b0;
    logic            RESET;
    logic            ps2_valid;
    logic [7:0]      ps2_byte;
    logic [7:0][7:0] KM;
    logic            kbd_reset;

    always #5 sys_clock = ~sys_clock;

    lm80c_ps2_matrix #(.E1_SKIP(E1_SKIP), .RESET_PULSE(RESET_PULSE)) dut (
        .sys_clock (sys_clock),
        .RESET     (RESET),
        .ps2_valid (ps2_valid),
        .ps2_byte  (ps2_byte),
        .KM        (KM),
        .kbd_reset (kbd_reset)
    );

    // Key table: {ext, byte} and row*8+col.
    logic [8:0] tbl_key[NK] = '{9'h01C, 9'h01A, 9'h029, 9'h05A, 9'h012, 9'h014, 9'h011, 9'h175, 9'h171};
    int         tbl_pos[NK] = '{17, 42, 60, 1, 48, 49, 50, 6, 7};

    // Reference model: bytes of the sequence in progress, and which keys are held.
    logic [7:0] seq[$];
    bit         held[8][8];
    bit         ctrl_h, alt_h, del_h;

    // Entry: {is_reset, pulse_start, km[63:0]}.
    logic [65:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [63:0] model_km();
        logic [63:0] v;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                v[r*8+c] = !held[r][c];
        return v;
    endfunction

    task automatic model_reset();
        seq.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                held[r][c] = 1'b0;
        ctrl_h = 1'b0;
        alt_h  = 1'b0;
        del_h  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit start);
        bit has_e0, has_f0, was_all;
        start = 1'b0;
        if (seq.size() > 0 && seq[0] == 8'hE1) begin
            seq.push_back(b);
            if (seq.size() == E1_SKIP + 1) seq.delete();
            return;
        end
        if (b == 8'h00 || b == 8'hFF) begin
            model_reset();
            return;
        end
        if (seq.size() == 0 && (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) return;
        if (seq.size() == 0 && b == 8'hE1) begin
            seq.push_back(b);
            return;
        end
        has_e0 = 1'b0;
        has_f0 = 1'b0;
        foreach (seq[i]) begin
            if (seq[i] == 8'hE0) has_e0 = 1'b1;
            if (seq[i] == 8'hF0) has_f0 = 1'b1;
        end
        if (!has_f0 && (b == 8'hE0 || b == 8'hF0)) begin
            seq.push_back(b);
            return;
        end
        seq.delete();
        if (has_e0 && (b == 8'h12 || b == 8'h59)) return;
        for (int k = 0; k < NK; k++)
            if (tbl_key[k] == {has_e0, b}) held[tbl_pos[k] / 8][tbl_pos[k] % 8] = !has_f0;
        was_all = ctrl_h && alt_h && del_h;
        if (b == 8'h14) ctrl_h = !has_f0;
        if (b == 8'h11) alt_h  = !has_f0;
        if (b == 8'h71) del_h  = !has_f0;
`ifdef LM80C_KBD_RESET_COMBO_EN
        start = (ctrl_h && alt_h && del_h) && !was_all;
`endif
    endtask

    task automatic send(input logic [7:0] b);
        bit st;
        model_byte(b, st);
        ps2_valid = 1'b1;
        ps2_byte  = b;
        exp_q.push_back({1'b0, st, model_km()});
        @(negedge sys_clock);
        ps2_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clock);
    endtask

    task automatic do_reset(input int n);
        RESET     = 1'b1;
        ps2_valid = 1'b0;
        model_reset();
        repeat (n) begin
            exp_q.push_back({1'b1, 1'b0, model_km()});
            @(negedge sys_clock);
        end
        RESET = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per strobe/reset cycle, checks every cycle.
    initial begin
        logic        v, r, armed;
        logic [65:0] e;
        logic [63:0] last_km;
        int          pulse_left;
        armed      = 1'b0;
        last_km    = '1;
        pulse_left = 0;
        forever begin
            @(posedge sys_clock);
            v = ps2_valid;
            r = RESET;
            @(negedge sys_clock);
            if (v || r) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got event with empty queue, required queued entry at %0t", $time);
                end else begin
                    e       = exp_q.pop_front();
                    last_km = e[63:0];
                    if (e[65]) begin
                        pulse_left = 0;
                        armed      = 1'b1;
                    end else if (e[64]) begin
                        pulse_left = RESET_PULSE;
                    end
                end
            end
            if (armed) begin
                check("km", KM, last_km);
                check("kbd_reset", {63'd0, kbd_reset}, {63'd0, pulse_left != 0});
                if (pulse_left > 0) pulse_left--;
            end
        end
    end

    initial begin
        int k, waited;
        RESET     = 1'b1;
        ps2_valid = 1'b0;
        ps2_byte  = 8'h00;
        do_reset(3);

        send(8'h1C); idle(2); send(8'hF0); send(8'h1C); idle(2);
        send(8'hE0); send(8'h75); send(8'h5A); idle(1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h71); idle(1);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h29); idle(2);
        send(8'h1C); send(8'h1A); send(8'hFF); idle(1);
        send(8'hAA); send(8'hFA); send(8'h29); idle(2);
        send(8'hE0); do_reset(1); send(8'h75); send(8'h5A); idle(2);

        do_reset(1);
        send(8'h14); send(8'h11); send(8'hE0); send(8'h71); idle(20);
        send(8'hE0); send(8'h71); idle(20);
        send(8'hF0); send(8'h14); send(8'h14); idle(20);
        send(8'h00); idle(2);

        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 99);
            if (k < 2)       send($urandom_range(0, 1) != 0 ? 8'hFF : 8'h00);
            else if (k < 4)  send(8'hE1);
            else if (k == 4) do_reset(1);
            else if (k < 28) send($urandom_range(0, 1) != 0 ? 8'hE0 : 8'hF0);
            else if (k < 34) send(8'($urandom_range(0, 255)));
            else if (k < 38) send($urandom_range(0, 1) != 0 ? 8'hAA : 8'h59);
            else begin
                case ($urandom_range(0, 8))
                    0: send(8'h1C);
                    1: send(8'h1A);
                    2: send(8'h29);
                    3: send(8'h5A);
                    4: send(8'h12);
                    5: send(8'h14);
                    6: send(8'h11);
                    7: send(8'h75);
                    default: send(8'h71);
                endcase
            end
            idle($urandom_range(0, 2));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            idle(1);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: got %0d entries left, required 0", exp_q.size());
        end
        idle(RESET_PULSE + 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
